// File: rtl/vector_mask_result_accumulator_pkg.sv
// Shared types for the vector mask result accumulator: element bit modes,
// accumulator FSM states and the default mask width.
package dragonfang_pkg;

  localparam int MASK_WIDTH_DEFAULT = 64;

  typedef enum logic [1:0] {
    ENABLED_64BIT_MODE = 2'd0,
    ENABLED_32BIT_MODE = 2'd1
  } bit_mode_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ACCUMULATE = 2'd1,
    DRAIN      = 2'd2
  } mask_accumulator_state_t;

  // Only the two enumerated modes produce mask bits; any other encoding
  // behaves like an empty instruction.
  function automatic logic mode_supported(input bit_mode_t mode);
    logic ok;
    case (mode)
      ENABLED_64BIT_MODE: ok = 1'b1;
      ENABLED_32BIT_MODE: ok = 1'b1;
      default:            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/vector_mask_result_accumulator_bit_inserter.sv
// Combinational insertion of one compare beat into the mask image.
// 64-bit mode writes one element, 32-bit mode writes up to two; no bit at or
// beyond vl is ever written and the pointer never moves past vl.
module vector_mask_bit_inserter
  import dragonfang_pkg::*;
#(
  parameter int MASK_WIDTH = MASK_WIDTH_DEFAULT,
  parameter int VL_WIDTH   = $clog2(MASK_WIDTH) + 1
) (
  input  logic [MASK_WIDTH-1:0] mask,
  input  logic [VL_WIDTH-1:0]   ptr,
  input  logic [VL_WIDTH-1:0]   vl,
  input  bit_mode_t             mode,
  input  logic [1:0]            vd,
  output logic [MASK_WIDTH-1:0] mask_next,
  output logic [VL_WIDTH-1:0]   ptr_next
);

  logic [VL_WIDTH-1:0] ptr_plus1;
  logic                lo_ok;
  logic                hi_ok;

  // Per-bit write enables and pointer advance for the current beat.
  always_comb begin
    mask_next = mask;
    ptr_next  = ptr;
    ptr_plus1 = ptr + VL_WIDTH'(1);
    lo_ok     = (ptr < vl);
    hi_ok     = (ptr_plus1 < vl);
    case (mode)
      ENABLED_64BIT_MODE: begin
        for (int i = 0; i < MASK_WIDTH; i++) begin
          if (lo_ok && (VL_WIDTH'(i) == ptr)) begin
            mask_next[i] = vd[0];
          end else begin
            mask_next[i] = mask[i];
          end
        end
        ptr_next = lo_ok ? ptr_plus1 : ptr;
      end
      ENABLED_32BIT_MODE: begin
        for (int i = 0; i < MASK_WIDTH; i++) begin
          if (lo_ok && (VL_WIDTH'(i) == ptr)) begin
            mask_next[i] = vd[0];
          end else if (hi_ok && (VL_WIDTH'(i) == ptr_plus1)) begin
            mask_next[i] = vd[1];
          end else begin
            mask_next[i] = mask[i];
          end
        end
        if (hi_ok) begin
          ptr_next = ptr + VL_WIDTH'(2);
        end else if (lo_ok) begin
          ptr_next = ptr_plus1;
        end else begin
          ptr_next = ptr;
        end
      end
      default: begin
        mask_next = mask;
        ptr_next  = vl;
      end
    endcase
  end

endmodule

// File: rtl/vector_mask_result_accumulator.sv
// Vector mask result accumulator: gathers per-beat FP compare bits into one
// RVV mask register image and hands it to writeback over valid/ready.
// Build option DRAGONFANG_MASK_TAIL_AGNOSTIC_EN: tail bits [MASK_WIDTH-1:vl]
// are set to 1; otherwise they are cleared to 0.
module vector_mask_result_accumulator
  import dragonfang_pkg::*;
#(
  parameter int MASK_WIDTH = MASK_WIDTH_DEFAULT,
  parameter int VL_WIDTH   = $clog2(MASK_WIDTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [VL_WIDTH-1:0]   start_vl,
  input  bit_mode_t             start_bit_mode,
  input  logic                  compare_valid,
  output logic                  compare_ready,
  input  logic [63:0]           compare_vd,
  output logic                  mask_valid,
  input  logic                  mask_ready,
  output logic [MASK_WIDTH-1:0] mask_data,
  output logic                  busy
);

  localparam logic [VL_WIDTH-1:0] VL_MAX = VL_WIDTH'(MASK_WIDTH);

  mask_accumulator_state_t state, state_next;
  logic [MASK_WIDTH-1:0]   mask, mask_next;
  logic [VL_WIDTH-1:0]     ptr, ptr_next;
  logic [VL_WIDTH-1:0]     vl, vl_next;
  bit_mode_t               mode, mode_next;
  logic [VL_WIDTH-1:0]     vl_sat;
  logic [MASK_WIDTH-1:0]   ins_mask;
  logic [VL_WIDTH-1:0]     ins_ptr;
  logic                    unused_vd_upper;

  // Bits at or above vl.
  function automatic logic [MASK_WIDTH-1:0] tail_bits(input logic [VL_WIDTH-1:0] v);
    logic [MASK_WIDTH-1:0] t;
    for (int i = 0; i < MASK_WIDTH; i++) begin
      t[i] = (VL_WIDTH'(i) >= v);
    end
    return t;
  endfunction

  // Force the tail region to the configured fill value.
  function automatic logic [MASK_WIDTH-1:0] apply_tail(input logic [MASK_WIDTH-1:0] m,
                                                      input logic [VL_WIDTH-1:0]   v);
`ifdef DRAGONFANG_MASK_TAIL_AGNOSTIC_EN
    return m | tail_bits(v);
`else
    return m & ~tail_bits(v);
`endif
  endfunction

  assign unused_vd_upper = ^compare_vd[63:2];

  vector_mask_bit_inserter #(
    .MASK_WIDTH(MASK_WIDTH),
    .VL_WIDTH  (VL_WIDTH)
  ) u_inserter (
    .mask     (mask),
    .ptr      (ptr),
    .vl       (vl),
    .mode     (mode),
    .vd       (compare_vd[1:0]),
    .mask_next(ins_mask),
    .ptr_next (ins_ptr)
  );

  assign start_ready   = (state == IDLE) && !reset;
  assign compare_ready = (state == ACCUMULATE);
  assign mask_valid    = (state == DRAIN);
  assign busy          = (state != IDLE);
  assign mask_data     = mask;

  // Next-state and datapath decode; flush overrides every handshake.
  always_comb begin
    state_next = state;
    mask_next  = mask;
    ptr_next   = ptr;
    vl_next    = vl;
    mode_next  = mode;
    vl_sat     = (start_vl > VL_MAX) ? VL_MAX : start_vl;
    if (flush) begin
      state_next = IDLE;
      ptr_next   = '0;
      mask_next  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            mode_next = start_bit_mode;
            ptr_next  = '0;
            if ((vl_sat == '0) || !mode_supported(start_bit_mode)) begin
              vl_next    = '0;
              mask_next  = apply_tail('0, '0);
              state_next = DRAIN;
            end else begin
              vl_next    = vl_sat;
              mask_next  = '0;
              state_next = ACCUMULATE;
            end
          end else begin
            state_next = IDLE;
          end
        end
        ACCUMULATE: begin
          if (compare_valid) begin
            ptr_next = ins_ptr;
            if (ins_ptr >= vl) begin
              mask_next  = apply_tail(ins_mask, vl);
              state_next = DRAIN;
            end else begin
              mask_next  = ins_mask;
              state_next = ACCUMULATE;
            end
          end else begin
            state_next = ACCUMULATE;
          end
        end
        DRAIN: begin
          if (mask_ready) begin
            state_next = IDLE;
          end else begin
            state_next = DRAIN;
          end
        end
        default: begin
          state_next = IDLE;
          ptr_next   = '0;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      mask  <= '0;
      ptr   <= '0;
      vl    <= '0;
      mode  <= ENABLED_64BIT_MODE;
    end else begin
      state <= state_next;
      mask  <= mask_next;
      ptr   <= ptr_next;
      vl    <= vl_next;
      mode  <= mode_next;
    end
  end

endmodule

// File: tb/tb_vector_mask_result_accumulator.sv
// Directed testbench for vector_mask_result_accumulator (MASK_WIDTH = 64).
// Honors DRAGONFANG_MASK_TAIL_AGNOSTIC_EN for expected tail values.
module tb_vector_mask_result_accumulator;
  import dragonfang_pkg::*;

  localparam int MW = 64;
  localparam int VW = 7;

`ifdef DRAGONFANG_MASK_TAIL_AGNOSTIC_EN
  localparam logic [63:0] EXP_T1   = 64'hFFFF_FFFF_FFFF_FFFD;
  localparam logic [63:0] EXP_T2   = 64'hFFFF_FFFF_FFFF_FFF7;
  localparam logic [63:0] EXP_EMPTY = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] EXP_VL1_0 = 64'hFFFF_FFFF_FFFF_FFFE;
  localparam logic [63:0] EXP_VL1_1 = 64'hFFFF_FFFF_FFFF_FFFF;
`else
  localparam logic [63:0] EXP_T1   = 64'h0000_0000_0000_0005;
  localparam logic [63:0] EXP_T2   = 64'h0000_0000_0000_0017;
  localparam logic [63:0] EXP_EMPTY = 64'h0000_0000_0000_0000;
  localparam logic [63:0] EXP_VL1_0 = 64'h0000_0000_0000_0000;
  localparam logic [63:0] EXP_VL1_1 = 64'h0000_0000_0000_0001;
`endif

  logic          clock = 1'b0;
  logic          reset, flush, start_valid, start_ready;
  logic [VW-1:0] start_vl;
  bit_mode_t     start_bit_mode;
  logic          compare_valid, compare_ready;
  logic [63:0]   compare_vd;
  logic          mask_valid, mask_ready, busy;
  logic [MW-1:0] mask_data;

  int n_checks = 0;
  int n_fail   = 0;

  vector_mask_result_accumulator #(.MASK_WIDTH(MW)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_vl(start_vl), .start_bit_mode(start_bit_mode),
    .compare_valid(compare_valid), .compare_ready(compare_ready),
    .compare_vd(compare_vd),
    .mask_valid(mask_valid), .mask_ready(mask_ready),
    .mask_data(mask_data), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_instr(input logic [VW-1:0] v, input bit_mode_t m);
    start_valid    = 1'b1;
    start_vl       = v;
    start_bit_mode = m;
    step();
    start_valid = 1'b0;
  endtask

  task automatic beat(input logic [1:0] vd);
    compare_valid = 1'b1;
    compare_vd    = {62'd0, vd};
    step();
    compare_valid = 1'b0;
  endtask

  task automatic drain();
    mask_ready = 1'b1;
    step();
    mask_ready = 1'b0;
  endtask

  initial begin
    int acc;
    logic [63:0] held;
    reset = 1'b1; flush = 1'b0; start_valid = 1'b0; start_vl = '0;
    start_bit_mode = ENABLED_64BIT_MODE; compare_valid = 1'b0;
    compare_vd = 64'd0; mask_ready = 1'b0;
    step(); step();
    check_eq("rst_outputs", {59'd0, start_ready, compare_ready, mask_valid, busy, 1'b0}, 64'd0);
    check_eq("rst_mask", mask_data, 64'd0);
    reset = 1'b0;
    step();
    check_eq("idle_start_ready", {63'd0, start_ready}, 64'd1);

    // 1: 64-bit, vl=3, beats 1,0,1
    start_instr(7'd3, ENABLED_64BIT_MODE);
    check_eq("t1_accum", {62'd0, compare_ready, busy}, 64'd3);
    beat(2'b01); beat(2'b00);
    check_eq("t1_no_early_valid", {63'd0, mask_valid}, 64'd0);
    beat(2'b01);
    check_eq("t1_valid_latency", {63'd0, mask_valid}, 64'd1);
    check_eq("t1_mask", mask_data, EXP_T1);
    drain();
    check_eq("t1_idle", {61'd0, start_ready, mask_valid, busy}, 64'd4);
    check_eq("t1_mask_kept", mask_data, EXP_T1);

    // 2: 32-bit, vl=5, beats 11,01,11 then a 4th offered beat
    start_instr(7'd5, ENABLED_32BIT_MODE);
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      compare_valid = 1'b1;
      compare_vd    = (i == 1) ? 64'd1 : 64'd3;
      if (compare_ready) acc++;
      step();
    end
    compare_valid = 1'b0;
    check_eq("t2_beats", 64'(acc), 64'd3);
    check_eq("t2_valid", {63'd0, mask_valid}, 64'd1);
    check_eq("t2_mask", mask_data, EXP_T2);
    drain();

    // 3: vl=0 goes straight to DRAIN, no compare_ready
    start_instr(7'd0, ENABLED_64BIT_MODE);
    check_eq("t3_drain", {62'd0, mask_valid, compare_ready}, 64'd2);
    check_eq("t3_mask", mask_data, EXP_EMPTY);
    drain();
    // unsupported mode behaves as vl=0
    start_instr(7'd5, bit_mode_t'(2'd2));
    check_eq("t3_badmode_drain", {62'd0, mask_valid, compare_ready}, 64'd2);
    check_eq("t3_badmode_mask", mask_data, EXP_EMPTY);

    // 4: DRAIN stall with start_valid held
    held = mask_data;
    start_valid = 1'b1; start_vl = 7'd1; start_bit_mode = ENABLED_64BIT_MODE;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("t4_stall", {62'd0, mask_valid, start_ready}, 64'd2);
      check_eq("t4_mask_stable", mask_data, held);
    end
    mask_ready = 1'b1;
    step();
    mask_ready = 1'b0;
    check_eq("t4_released", {62'd0, mask_valid, start_ready}, 64'd1);
    step();
    start_valid = 1'b0;
    check_eq("t4_start_taken", {63'd0, compare_ready}, 64'd1);
    beat(2'b01);
    check_eq("t4_mask", mask_data, EXP_VL1_1);
    drain();

    // 5: flush after 2 of 4 beats, with a concurrent beat
    start_instr(7'd4, ENABLED_64BIT_MODE);
    beat(2'b01); beat(2'b01);
    flush = 1'b1; compare_valid = 1'b1; compare_vd = 64'd1;
    step();
    flush = 1'b0; compare_valid = 1'b0;
    check_eq("t5_flushed", {61'd0, busy, mask_valid, start_ready}, 64'd1);
    flush = 1'b1; start_valid = 1'b1; start_vl = 7'd2;
    step();
    flush = 1'b0; start_valid = 1'b0;
    check_eq("t5_flush_blocks_start", {62'd0, busy, mask_valid}, 64'd0);
    start_instr(7'd1, ENABLED_64BIT_MODE);
    beat(2'b00);
    check_eq("t5_clean_mask", mask_data, EXP_VL1_0);
    drain();

    // 6: reset mid-ACCUMULATE with concurrent beat, then vl saturation
    start_instr(7'd4, ENABLED_64BIT_MODE);
    beat(2'b01);
    reset = 1'b1; compare_valid = 1'b1; compare_vd = 64'd1;
    step();
    compare_valid = 1'b0;
    check_eq("t6_rst_outputs", {60'd0, start_ready, compare_ready, mask_valid, busy}, 64'd0);
    check_eq("t6_rst_mask", mask_data, 64'd0);
    reset = 1'b0;
    step();
    start_instr(7'd70, ENABLED_64BIT_MODE);
    acc = 0;
    for (int i = 0; i < 100 && !mask_valid; i++) begin
      compare_valid = 1'b1;
      compare_vd    = {63'd0, acc[0]};
      if (compare_ready) acc++;
      step();
    end
    compare_valid = 1'b0;
    check_eq("t6_sat_done", {63'd0, mask_valid}, 64'd1);
    check_eq("t6_sat_beats", 64'(acc), 64'd64);
    check_eq("t6_sat_mask", mask_data, 64'hAAAA_AAAA_AAAA_AAAA);
    drain();
    check_eq("t6_final_idle", {62'd0, busy, start_ready}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
